// File: rtl/cluster_collector_pkg.sv
// rtl/cluster_collector_pkg.sv - shared cluster word definitions for encoder, collector and serializer
package cluster_collector_pkg;

  localparam int MXCLUSTERS = 8;
  localparam int MXADRBITS  = 11;
  localparam int MXCNTBITS  = 3;
  localparam int CLWORD_W   = MXCNTBITS + MXADRBITS;
  localparam int PASS_W     = 3;
  localparam int IDX_W      = $clog2(MXCLUSTERS);
  localparam int CNT_W      = $clog2(MXCLUSTERS + 1);

  localparam logic [MXADRBITS-1:0] INVALID_ADR = 11'h7FF;

  typedef logic [CLWORD_W-1:0] cluster_word_t;
  typedef logic [MXCLUSTERS-1:0][CLWORD_W-1:0] cluster_frame_t;

  // Unused slots carry size 0 and the "no cluster" address.
  localparam cluster_word_t EMPTY_WORD = {{MXCNTBITS{1'b0}}, INVALID_ADR};

  typedef enum logic {
    ST_IDLE,
    ST_COLLECT
  } state_e;

  function automatic cluster_word_t pack_cluster(input logic [MXCNTBITS-1:0] c,
                                                 input logic [MXADRBITS-1:0] a);
    return {c, a};
  endfunction

endpackage

// File: rtl/cluster_collector_if.sv
// rtl/cluster_collector_if.sv - priority-result input and packed-frame output bundle
interface cluster_collector_if;
  import cluster_collector_pkg::*;

  logic                           in_valid;
  logic                           cluster_found;
  logic [MXADRBITS-1:0]           adr;
  logic [MXCNTBITS-1:0]           cnt;
  logic [PASS_W-1:0]              pass;

  logic                           frame_valid;
  logic [MXCLUSTERS*CLWORD_W-1:0] clusters_out;
  logic [CNT_W-1:0]               cluster_count;
  logic                           overflow;
  logic                           pass_err;

  modport master (
    output in_valid, cluster_found, adr, cnt, pass,
    input  frame_valid, clusters_out, cluster_count, overflow, pass_err
  );

  modport slave (
    input  in_valid, cluster_found, adr, cnt, pass,
    output frame_valid, clusters_out, cluster_count, overflow, pass_err
  );

endinterface

// File: rtl/cluster_collector_frame_edge_detect.sv
// rtl/cluster_collector_frame_edge_detect.sv - samples the slow frame clock and pulses on its rising edge
module cluster_collector_frame_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic frame_clock,
  output logic frame_edge
);

  logic [1:0] fs_q;
  logic [1:0] fs_d;

  always_comb begin
    fs_d = {fs_q[0], frame_clock};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fs_q <= 2'b00;
    end else begin
      fs_q <= fs_d;
    end
  end

  assign frame_edge = (fs_q == 2'b01);

endmodule

// File: rtl/cluster_collector.sv
// rtl/cluster_collector.sv - gathers per-pass cluster results into one packed word per frame period
module cluster_collector
  import cluster_collector_pkg::*;
(
  input logic          clock,
  input logic          reset,
  input logic          frame_clock,
  cluster_collector_if.slave bus
);

  logic frame_edge;

  cluster_collector_frame_edge_detect u_edge (
    .clock       (clock),
    .reset       (reset),
    .frame_clock (frame_clock),
    .frame_edge  (frame_edge)
  );

  state_e            state_q, state_d;
  cluster_frame_t    slots_q, slots_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_acc_q, ovf_acc_d;
  logic              perr_acc_q, perr_acc_d;
  logic [PASS_W-1:0] exp_pass_q, exp_pass_d;

  logic              frame_valid_q, frame_valid_d;
  cluster_frame_t    clusters_q, clusters_d;
  logic [CNT_W-1:0]  cluster_count_q, cluster_count_d;
  logic              overflow_q, overflow_d;
  logic              pass_err_q, pass_err_d;

  always_comb begin
    state_d         = state_q;
    slots_d         = slots_q;
    count_d         = count_q;
    ovf_acc_d       = ovf_acc_q;
    perr_acc_d      = perr_acc_q;
    exp_pass_d      = exp_pass_q;
    frame_valid_d   = 1'b0;
    clusters_d      = clusters_q;
    cluster_count_d = cluster_count_q;
    overflow_d      = overflow_q;
    pass_err_d      = pass_err_q;

    // The edge closes the running frame first, so a result on the edge cycle lands in the fresh one.
    if (frame_edge) begin
      if (state_q == ST_COLLECT) begin
        frame_valid_d   = 1'b1;
        clusters_d      = slots_q;
        cluster_count_d = count_q;
        overflow_d      = ovf_acc_q;
        pass_err_d      = perr_acc_q;
      end
      state_d    = ST_COLLECT;
      slots_d    = {MXCLUSTERS{EMPTY_WORD}};
      count_d    = '0;
      ovf_acc_d  = 1'b0;
      perr_acc_d = 1'b0;
      exp_pass_d = '0;
    end

    if (state_d == ST_COLLECT && bus.in_valid) begin
      if (bus.cluster_found) begin
        if (count_d < CNT_W'(MXCLUSTERS)) begin
          slots_d[count_d[IDX_W-1:0]] = pack_cluster(bus.cnt, bus.adr);
          count_d = count_d + 1'b1;
        end else begin
          ovf_acc_d = 1'b1;
        end
      end
      if (bus.pass != exp_pass_d) begin
        perr_acc_d = 1'b1;
      end
      exp_pass_d = exp_pass_d + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      slots_q         <= {MXCLUSTERS{EMPTY_WORD}};
      count_q         <= '0;
      ovf_acc_q       <= 1'b0;
      perr_acc_q      <= 1'b0;
      exp_pass_q      <= '0;
      frame_valid_q   <= 1'b0;
      clusters_q      <= {MXCLUSTERS{EMPTY_WORD}};
      cluster_count_q <= '0;
      overflow_q      <= 1'b0;
      pass_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      slots_q         <= slots_d;
      count_q         <= count_d;
      ovf_acc_q       <= ovf_acc_d;
      perr_acc_q      <= perr_acc_d;
      exp_pass_q      <= exp_pass_d;
      frame_valid_q   <= frame_valid_d;
      clusters_q      <= clusters_d;
      cluster_count_q <= cluster_count_d;
      overflow_q      <= overflow_d;
      pass_err_q      <= pass_err_d;
    end
  end

  assign bus.frame_valid   = frame_valid_q;
  assign bus.clusters_out  = clusters_q;
  assign bus.cluster_count = cluster_count_q;
  assign bus.overflow      = overflow_q;
  assign bus.pass_err      = pass_err_q;

endmodule

// File: tb/tb_cluster_collector.sv
// tb/tb_cluster_collector.sv - directed bench with a queue-based frame model for cluster_collector
module tb_cluster_collector;
  import cluster_collector_pkg::*;

  logic clock;
  logic reset;
  logic frame_clock;

  cluster_collector_if bus ();

  cluster_collector u_dut (
    .clock       (clock),
    .reset       (reset),
    .frame_clock (frame_clock),
    .bus         (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_cmp  = 0;
  int n_fail = 0;
  int fv_seen = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: results of the open frame are kept as a plain list.
  logic [1:0]   m_hist = 2'b00;
  bit           m_active = 1'b0;
  bit           m_edge;
  logic [13:0]  m_q[$];
  bit           m_ovf = 1'b0;
  bit           m_perr = 1'b0;
  int           m_exp = 0;

  logic         e_valid = 1'b0;
  logic [111:0] e_clusters = {8{14'h07FF}};
  logic [3:0]   e_count = 4'd0;
  logic         e_ovf = 1'b0;
  logic         e_perr = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      m_hist = 2'b00; m_active = 1'b0; m_q.delete();
      m_ovf = 1'b0; m_perr = 1'b0; m_exp = 0;
      e_valid = 1'b0; e_clusters = {8{14'h07FF}}; e_count = 4'd0; e_ovf = 1'b0; e_perr = 1'b0;
    end else begin
      m_edge = (m_hist == 2'b01);
      m_hist = {m_hist[0], frame_clock};
      e_valid = 1'b0;
      if (m_edge) begin
        if (m_active) begin
          e_valid = 1'b1;
          for (int i = 0; i < 8; i++)
            e_clusters[i*14 +: 14] = (i < m_q.size()) ? m_q[i] : 14'h07FF;
          e_count = 4'(m_q.size());
          e_ovf = m_ovf;
          e_perr = m_perr;
        end
        m_q.delete(); m_ovf = 1'b0; m_perr = 1'b0; m_exp = 0; m_active = 1'b1;
      end
      if (m_active && bus.in_valid) begin
        if (bus.cluster_found) begin
          if (m_q.size() < 8) m_q.push_back({bus.cnt, bus.adr});
          else m_ovf = 1'b1;
        end
        if (int'(bus.pass) != m_exp) m_perr = 1'b1;
        m_exp = (m_exp + 1) % 8;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("frame_valid", 128'(bus.frame_valid), 128'(e_valid));
      chk("clusters_out", 128'(bus.clusters_out), 128'(e_clusters));
      chk("cluster_count", 128'(bus.cluster_count), 128'(e_count));
      chk("overflow", 128'(bus.overflow), 128'(e_ovf));
      chk("pass_err", 128'(bus.pass_err), 128'(e_perr));
      if (bus.frame_valid === 1'b1) fv_seen++;
    end
  end

  int phase = 7;
  int fc_period = 8;
  int fv0;

  task automatic step();
    @(negedge clock);
    #1;
    phase = (phase + 1) % fc_period;
    frame_clock = (phase < fc_period / 2);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.cluster_found = 1'b0;
    bus.adr = 11'h7FF;
    bus.cnt = 3'd0;
    bus.pass = 3'd0;
  endtask

  task automatic drive(input logic f, input logic [10:0] a, input logic [2:0] c, input logic [2:0] p);
    bus.in_valid = 1'b1;
    bus.cluster_found = f;
    bus.adr = a;
    bus.cnt = c;
    bus.pass = p;
    step();
  endtask

  // Leaves the bench at the negedge just before the posedge that sees frame_edge.
  task automatic sync_edge();
    idle();
    step();
    while (phase != 1) step();
  endtask

  task automatic finish_frame();
    idle();
    while (phase != 1) step();
    step();
  endtask

  initial begin
    reset = 1'b1;
    frame_clock = 1'b0;
    idle();
    step();
    chk_en = 1'b1;
    while (phase != 5) step();
    chk("rst_count", 128'(bus.cluster_count), 128'(4'd0));
    chk("rst_clusters", 128'(bus.clusters_out), 128'({8{14'h07FF}}));
    chk("rst_frame_valid", 128'(bus.frame_valid), 128'(1'b0));
    reset = 1'b0;

    // Three empty frame periods: first edge only arms collection.
    fv0 = fv_seen;
    sync_edge();
    repeat (17) step();
    chk("empty_strobes", 128'(fv_seen - fv0), 128'(2));
    chk("empty_count", 128'(bus.cluster_count), 128'(4'd0));

    // Eight passes, hits on passes 0 and 3.
    sync_edge();
    for (int i = 0; i < 8; i++) begin
      if (i == 0)      drive(1'b1, 11'd5, 3'd2, 3'(i));
      else if (i == 3) drive(1'b1, 11'd700, 3'd7, 3'(i));
      else             drive(1'b0, 11'h7FF, 3'd0, 3'(i));
    end
    finish_frame();
    chk("two_slot0", 128'(bus.clusters_out[13:0]), 128'(14'h1005));
    chk("two_slot1", 128'(bus.clusters_out[27:14]), 128'(14'h3ABC));
    chk("two_slot2", 128'(bus.clusters_out[41:28]), 128'(14'h07FF));
    chk("two_count", 128'(bus.cluster_count), 128'(4'd2));

    // Ten clusters in one longer frame.
    fc_period = 16;
    sync_edge();
    for (int i = 0; i < 10; i++) drive(1'b1, 11'(i), 3'(i % 8), 3'(i % 8));
    finish_frame();
    chk("ovf_count", 128'(bus.cluster_count), 128'(4'd8));
    chk("ovf_flag", 128'(bus.overflow), 128'(1'b1));
    chk("ovf_slot7", 128'(bus.clusters_out[111:98]), 128'(14'h3807));
    chk("ovf_perr", 128'(bus.pass_err), 128'(1'b0));
    finish_frame();
    chk("ovf_cleared", 128'(bus.overflow), 128'(1'b0));
    fc_period = 8;

    // Pass sequence 0,1,3 then a clean frame.
    drive(1'b1, 11'd100, 3'd1, 3'd0);
    drive(1'b1, 11'd101, 3'd1, 3'd1);
    drive(1'b1, 11'd102, 3'd1, 3'd3);
    finish_frame();
    chk("perr_set", 128'(bus.pass_err), 128'(1'b1));
    chk("perr_count", 128'(bus.cluster_count), 128'(4'd3));
    drive(1'b1, 11'd110, 3'd1, 3'd0);
    drive(1'b1, 11'd111, 3'd1, 3'd1);
    finish_frame();
    chk("perr_clear", 128'(bus.pass_err), 128'(1'b0));

    // Result arriving on the edge cycle goes to the new frame.
    drive(1'b1, 11'd10, 3'd3, 3'd0);
    idle();
    while (phase != 1) step();
    drive(1'b1, 11'd42, 3'd5, 3'd0);
    idle();
    chk("edge_old_count", 128'(bus.cluster_count), 128'(4'd1));
    chk("edge_old_slot0", 128'(bus.clusters_out[13:0]), 128'(14'h180A));
    chk("edge_old_slot1", 128'(bus.clusters_out[27:14]), 128'(14'h07FF));
    finish_frame();
    chk("edge_new_slot0", 128'(bus.clusters_out[13:0]), 128'(14'h282A));
    chk("edge_new_count", 128'(bus.cluster_count), 128'(4'd1));
    chk("edge_new_perr", 128'(bus.pass_err), 128'(1'b0));

    // Mid-frame reset discards the partial frame.
    for (int i = 0; i < 4; i++) drive(1'b1, 11'(200 + i), 3'(i), 3'(i));
    idle();
    reset = 1'b1;
    step();
    chk("mid_rst_count", 128'(bus.cluster_count), 128'(4'd0));
    chk("mid_rst_clusters", 128'(bus.clusters_out), 128'({8{14'h07FF}}));
    chk("mid_rst_fv", 128'(bus.frame_valid), 128'(1'b0));
    reset = 1'b0;
    fv0 = fv_seen;
    sync_edge();
    repeat (8) step();
    chk("post_rst_no_emit", 128'(fv_seen - fv0), 128'(0));
    step();
    chk("post_rst_emit", 128'(fv_seen - fv0), 128'(1));
    chk("post_rst_count", 128'(bus.cluster_count), 128'(4'd0));

    repeat (4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
